// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcode encodings, MDU function codes and the
//               multiply/divide sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes (full table; the MDU only uses PASSB, ADD and SUB)
    localparam logic [3:0] c_ALU_PASSB = 4'b0000;
    localparam logic [3:0] c_ALU_PASSA = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_SUB   = 4'b0011;
    localparam logic [3:0] c_ALU_AND   = 4'b0100;
    localparam logic [3:0] c_ALU_OR    = 4'b0101;
    localparam logic [3:0] c_ALU_XOR   = 4'b0110;
    localparam logic [3:0] c_ALU_SLL   = 4'b0111;
    localparam logic [3:0] c_ALU_SRL   = 4'b1000;
    localparam logic [3:0] c_ALU_SRA   = 4'b1001;
    localparam logic [3:0] c_ALU_SLT   = 4'b1010;
    localparam logic [3:0] c_ALU_SLTU  = 4'b1011;

    // MDU function codes; the reserved code behaves as MUL
    localparam logic [1:0] c_FUNC_MUL  = 2'b00;
    localparam logic [1:0] c_FUNC_DIVU = 2'b01;
    localparam logic [1:0] c_FUNC_REMU = 2'b10;
    localparam logic [1:0] c_FUNC_RSVD = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_seq
// Description : Iterative unsigned MUL (low word) / DIVU / REMU sequencer that
//               borrows the shared 32-bit ALU one operation per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      func,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_c
);

    localparam int c_CNT_W = 6;

    mdu_state_t        r_state;
    mdu_state_t        w_state_nxt;
    logic [1:0]        r_func;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_is_mul;
    logic              w_mul_exit;
    logic              w_hi;
    logic [XLEN-1:0]   w_rs;
    logic              w_take;
    logic [XLEN-1:0]   w_sel;

    // Everything that is not DIVU/REMU (including the reserved code) is MUL
    assign w_is_mul   = (r_func != c_FUNC_DIVU) && (r_func != c_FUNC_REMU);
    // Early termination once no multiplier bits remain
    assign w_mul_exit = EARLY_OUT && (r_mplier == '0);
    // Restoring-division step: the shifted-out remainder MSB forces a subtract
    assign w_hi       = r_rem[XLEN-1];
    assign w_rs       = {r_rem[XLEN-2:0], r_q[XLEN-1]};
    assign w_take     = w_hi | alu_c;

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    // Live value in DONE, then the captured copy is held afterwards
    assign result = (r_state == S_DONE) ? w_sel : r_result;

    // Result select by latched function
    always_comb begin
        w_sel = r_acc;
        if (r_func == c_FUNC_DIVU) begin
            w_sel = r_q;
        end else if (r_func == c_FUNC_REMU) begin
            w_sel = r_rem;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and ALU operand/opcode drive
    always_comb begin
        w_state_nxt = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = c_ALU_PASSB;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_is_mul) begin
                    w_state_nxt = S_MUL;
                end else if (r_opb == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL: begin
                if (w_mul_exit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    alu_a  = r_acc;
                    alu_b  = r_mcand;
                    alu_op = c_ALU_ADD;
                    if (!EARLY_OUT && (r_cnt == c_CNT_W'(1))) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DIV: begin
                alu_a  = w_rs;
                alu_b  = r_opb;
                alu_op = c_ALU_SUB;
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add / restoring-divide datapath and result hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_func   <= c_FUNC_MUL;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_func <= func;
                        r_opa  <= src_a;
                        r_opb  <= src_b;
                    end
                end
                S_LOAD: begin
                    r_cnt <= c_CNT_W'(XLEN);
                    if (w_is_mul) begin
                        r_acc    <= '0;
                        r_mcand  <= r_opa;
                        r_mplier <= r_opb;
                    end else if (r_opb == '0) begin
                        r_q   <= '1;
                        r_rem <= r_opa;
                    end else begin
                        r_rem <= '0;
                        r_q   <= r_opa;
                    end
                end
                S_MUL: begin
                    if (!w_mul_exit) begin
                        if (r_mplier[0]) begin
                            r_acc <= alu_out;
                        end
                        r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                        r_cnt    <= r_cnt - c_CNT_W'(1);
                    end
                end
                S_DIV: begin
                    r_rem <= w_take ? alu_out : w_rs;
                    r_q   <= {r_q[XLEN-2:0], w_take};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                S_DONE: begin
                    r_result <= w_sel;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu_seq
// Description : Self-checking bench for alu_mdu_seq; runs an EARLY_OUT=1 and
//               an EARLY_OUT=0 instance side by side, each with its own ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  func = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;

    logic        busy1, done1, alu_c1;
    logic [31:0] result1, alu_a1, alu_b1, alu_out1;
    logic [3:0]  alu_op1;
    logic        busy0, done0, alu_c0;
    logic [31:0] result0, alu_a0, alu_b0, alu_out0;
    logic [3:0]  alu_op0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: PASSB / ADD / SUB (C = A>=B unsigned on SUB)
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'b0010: return {1'b0, a + b};
            4'b0011: return {(a >= b), a - b};
            default: return {1'b0, b};
        endcase
    endfunction

    assign {alu_c1, alu_out1} = alu_f(alu_a1, alu_b1, alu_op1);
    assign {alu_c0, alu_out0} = alu_f(alu_a0, alu_b0, alu_op0);

    alu_mdu_seq #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .src_a(src_a), .src_b(src_b), .busy(busy1), .done(done1),
        .result(result1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_out(alu_out1), .alu_c(alu_c1)
    );

    alu_mdu_seq #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .src_a(src_a), .src_b(src_b), .busy(busy0), .done(done0),
        .result(result0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
        .alu_out(alu_out0), .alu_c(alu_c0)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        if (f == 2'b01) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (f == 2'b10) return (b == 0) ? a : a % b;
        return a * b;
    endfunction

    function automatic int bitlen(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic bit is_div(input logic [1:0] f);
        return (f == 2'b01) || (f == 2'b10);
    endfunction

    // Cycle of the done pulse, start accepted in cycle 0
    function automatic int ref_lat(input logic [1:0] f, input logic [31:0] b, input bit early);
        if (is_div(f)) return (b == 0) ? 2 : 34;
        return early ? bitlen(b) + 3 : 34;
    endfunction

    // Number of cycles in which the ALU is asked for ADD/SUB
    function automatic int ref_ops(input logic [1:0] f, input logic [31:0] b, input bit early);
        if (is_div(f)) return (b == 0) ? 0 : 32;
        return early ? bitlen(b) : 32;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Issue one op and watch both instances cycle by cycle
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat1);
        int lat1 = -1, lat0 = -1, ops1 = 0, ops0 = 0, dn1 = 0, dn0 = 0, perr = 0;
        logic [31:0] r1 = '0, r0 = '0;
        @(negedge clk);
        if (busy1 || busy0) perr++;
        start = 1'b1; func = f; src_a = a; src_b = b;
        @(negedge clk);
        // scramble inputs to prove they were latched
        start = 1'b0; func = 2'($urandom); src_a = $urandom; src_b = $urandom;
        for (int k = 1; k <= 45; k++) begin
            if (k > 1) @(negedge clk);
            if (done1) begin dn1++; if (lat1 < 0) begin lat1 = k; r1 = result1; end end
            if (done0) begin dn0++; if (lat0 < 0) begin lat0 = k; r0 = result0; end end
            if (busy1 !== ((lat1 < 0) || (k == lat1))) perr++;
            if (busy0 !== ((lat0 < 0) || (k == lat0))) perr++;
            if (alu_op1 != 4'b0000) ops1++; else if (alu_a1 != 0 || alu_b1 != 0) perr++;
            if (alu_op0 != 4'b0000) ops0++; else if (alu_a0 != 0 || alu_b0 != 0) perr++;
        end
        check({tag, " result(early)"}, r1, exp_res);
        check({tag, " result(full)"}, r0, exp_res);
        check({tag, " latency(early)"}, lat1, exp_lat1);
        check({tag, " latency(full)"}, lat0, ref_lat(f, b, 1'b0));
        check({tag, " aluops(early)"}, ops1, ref_ops(f, b, 1'b1));
        check({tag, " aluops(full)"}, ops0, ref_ops(f, b, 1'b0));
        check({tag, " donepulses"}, dn1 * 16 + dn0, 32'd17);
        check({tag, " protocol errs"}, perr, 0);
        check({tag, " result held"}, result1, exp_res);
    endtask

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'd42,         6};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE,  5};
        vecs[2]  = '{2'b00, 32'd5,         32'd0,         32'd0,          3};
        vecs[3]  = '{2'b01, 32'd100,       32'd7,         32'd14,         34};
        vecs[4]  = '{2'b10, 32'd100,       32'd7,         32'd2,          34};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,          34};
        vecs[6]  = '{2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE,  34};
        vecs[7]  = '{2'b01, 32'h1234,      32'd0,         32'hFFFF_FFFF,  2};
        vecs[8]  = '{2'b10, 32'h1234,      32'd0,         32'h1234,       2};
        vecs[9]  = '{2'b11, 32'd3,         32'd5,         32'd15,         6};
        vecs[10] = '{2'b00, 32'h0001_0000, 32'h8000_0000, 32'd0,          35};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", {30'd0, busy1, busy0}, 0);
        check("reset done", {30'd0, done1, done0}, 0);
        check("reset result", result1 | result0, 0);
        check("reset alu_op", {24'd0, alu_op1, alu_op0}, 0);
        check("reset alu_a/b", alu_a1 | alu_b1 | alu_a0 | alu_b0, 0);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // Start pulses during busy and in the DONE cycle are ignored
        begin
            int dn = 0, lat = -1;
            logic [31:0] r = '0;
            @(negedge clk);
            start = 1'b1; func = 2'b01; src_a = 32'd100; src_b = 32'd7;
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k <= 45; k++) begin
                if (k > 1) @(negedge clk);
                if (done1) begin dn++; if (lat < 0) begin lat = k; r = result1; end end
                start = (k == 5) || (k == 34);
                func = 2'b00; src_a = 32'd3; src_b = 32'd3;
            end
            start = 1'b0;
            check("busy-start donepulses", dn, 1);
            check("busy-start latency", lat, 34);
            check("busy-start result", r, 32'd14);
            check("busy-start idle after", {31'd0, busy1}, 0);
        end

        // Reset in cycle 10 of a DIVU aborts without a done pulse
        begin
            int dn = 0;
            @(negedge clk);
            start = 1'b1; func = 2'b01; src_a = 32'd1000; src_b = 32'd3;
            @(negedge clk);
            start = 1'b0;
            repeat (9) @(negedge clk);   // now in cycle 10
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort busy", {30'd0, busy1, busy0}, 0);
            check("abort result", result1 | result0, 0);
            check("abort alu_op", {24'd0, alu_op1, alu_op0}, 0);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done1 || done0) dn++;
            end
            check("abort no done", dn, 0);
        end
        run_op("after-abort mul", 2'b00, 32'd7, 32'd6, 32'd42, 6);

        // Randomised operations against the reference model
        for (int n = 0; n < 30; n++) begin
            logic [1:0]  f = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 255));
                1: b = 32'd0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rnd%0d", n), f, a, b, ref_result(f, a, b), ref_lat(f, b, 1'b1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer that borrows the shared 32-bit ALU to run iterative unsigned MUL (low word), DIVU and REMU.
- Issues one ALU operation per cycle: ADD for shift-add multiply, SUB plus the C flag for restoring division.
- Sits beside the EX stage. It drives the ALU input mux while busy; the EX stage stalls on busy.

Parameters:
- XLEN, 32, operand/result width (fixed at 32; ALU is 32-bit)
- EARLY_OUT, 1, 1 = multiply terminates when remaining multiplier is zero; 0 = always 32 iterations

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- func  in  2  00 MUL, 01 DIVU, 10 REMU, 11 reserved (treated as MUL)
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse in the DONE state
- result  out  32  valid in DONE; held until the next accepted start
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU opcode
- alu_out  in  32  ALU result
- alu_c  in  1  ALU carry flag (A>=B unsigned on SUB)

Behaviour:
- One clock domain; reset is synchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, alu_a=0, alu_b=0, alu_op=PASSB (0000).
- rst_n low mid-operation aborts immediately. No done pulse follows; result is cleared.
- FSM states: IDLE, LOAD, MUL, DIV, DONE.
- IDLE: start=1 latches func/src_a/src_b, goes to LOAD. start in any other state is ignored (no queuing).
- LOAD, MUL setup: acc=0, mcand=src_a, mplier=src_b, goes to MUL.
- LOAD, DIV setup: if src_b==0, go straight to DONE with quotient 0xFFFFFFFF and remainder src_a. Otherwise rem=0, q=src_a, cnt=32, go to DIV.
- MUL state, mplier==0 (only checked when EARLY_OUT=1): go to DONE, no commit.
- MUL state, otherwise:
  - Drive alu_a=acc, alu_b=mcand, alu_op=ADD (0010).
  - If mplier[0]=1, acc<=alu_out.
  - mcand<<=1, mplier>>=1, both locally.
  - EARLY_OUT=0: exit after 32 iterations.
  - Overflow beyond 32 bits is discarded.
- DIV state, one bit per cycle:
  - hi = rem[31]; rs = {rem[30:0], q[31]}.
  - Drive alu_a=rs, alu_b=divisor, alu_op=SUB (0011).
  - If hi|alu_c: rem<=alu_out and shift qbit=1 into q. Else rem<=rs and shift qbit=0 into q.
  - cnt-- each cycle; go to DONE when cnt reaches 0 after the update.
- DONE: done=1, busy=1. result=acc (MUL), q (DIVU) or rem (REMU). Next state is IDLE.
- Outside MUL/DIV: alu_op=PASSB, alu_a=alu_b=0.
- Latency, with start accepted in cycle 0:
  - MUL: done in cycle N+3, where N = bit-length of src_b (0 for src_b=0). With EARLY_OUT=0, cycle 34.
  - DIVU/REMU: done in cycle 34.
  - Divide by zero: done in cycle 2.
- A start in the same cycle as DONE is ignored; it can be accepted the following cycle (IDLE).

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: PASSB=4'b0000, ADD=4'b0010, SUB=4'b0011 (and the remaining ALU encodings for other users).
  - MDU func codes.
  - The FSM state enum.
- Single module, no sub-module. The acc/rem/q shift registers and the 6-bit counter are inline.

Test Plan:
- MUL 7×6, EARLY_OUT=1 -> result=42 (0x2A), done in cycle 6, busy cycles 1–6.
- MUL 0xFFFFFFFF×2 -> result=0xFFFFFFFE, done in cycle 5. MUL 5×0 -> result=0, done in cycle 3.
- DIVU/REMU 100/7 -> q=14, r=2, done in cycle 34. While DIV: alu_op=0011 every cycle.
- DIVU 0xFFFFFFFF/0x80000001 -> q=1. REMU -> r=0x7FFFFFFE. This exercises the hi-bit path.
- Divide by zero, src_a=0x1234 -> DIVU 0xFFFFFFFF and REMU 0x1234, done in cycle 2.
- Robustness:
  - Start pulsed during busy -> ignored; exactly one done pulse.
  - rst_n low in cycle 10 of a DIVU -> IDLE, busy=0, result=0, no done.
  - New start afterwards completes normally.
